// File: rtl/fleet_placer.sv
// Deployment-phase sequencer: walks the fleet largest class first, previews each ship
// and issues a single-cycle commit strobe to the board memory. The memory acknowledges
// within the same cycle. When the whole fleet is placed the game moves to shooting.
module fleet_placer #(
  parameter int unsigned N_SHIP4 = 1,
  parameter int unsigned N_SHIP3 = 2,
  parameter int unsigned N_SHIP2 = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       left_btn,
  input  logic       right_btn,
  input  logic       ship_placed,
  output logic [1:0] play_status,
  output logic [3:0] dimension,
  output logic       direction,
  output logic       we,
  output logic [3:0] ships_left,
  output logic       place_err,
  output logic       fleet_done
);

  localparam logic [3:0] Cnt4Init  = 4'(N_SHIP4);
  localparam logic [3:0] Cnt3Init  = 4'(N_SHIP3);
  localparam logic [3:0] Cnt2Init  = 4'(N_SHIP2);
  localparam logic [3:0] TotalInit = 4'(N_SHIP4 + N_SHIP3 + N_SHIP2);

  typedef enum logic [1:0] {StIdle, StPlace, StCommit, StShoot} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt4_q, cnt4_d;
  logic [3:0] cnt3_q, cnt3_d;
  logic [3:0] cnt2_q, cnt2_d;
  logic [3:0] ships_left_q, ships_left_d;
  logic [3:0] dimension_q, dimension_d;
  logic       direction_q, direction_d;
  logic       we_q, we_d;
  logic       place_err_q, place_err_d;
  logic       fleet_done_q, fleet_done_d;
  logic [1:0] play_status_q, play_status_d;
  logic       lbtn_q, rbtn_q;
  logic       lclk, rclk;

  // Length of the first class that still has ships left; 0 when the fleet is empty.
  function automatic logic [3:0] first_dim(input logic [3:0] c4, input logic [3:0] c3,
                                           input logic [3:0] c2);
    if (c4 != 4'd0) return 4'd4;
    if (c3 != 4'd0) return 4'd3;
    if (c2 != 4'd0) return 4'd2;
    return 4'd0;
  endfunction

  assign lclk = left_btn & ~lbtn_q;
  assign rclk = right_btn & ~rbtn_q;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt4_d        = cnt4_q;
    cnt3_d        = cnt3_q;
    cnt2_d        = cnt2_q;
    ships_left_d  = ships_left_q;
    dimension_d   = dimension_q;
    direction_d   = direction_q;
    place_err_d   = 1'b0;
    we_d          = 1'b0;
    fleet_done_d  = 1'b0;
    play_status_d = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          if (ships_left_q == 4'd0) begin
            state_d = StShoot;
          end else begin
            state_d     = StPlace;
            dimension_d = first_dim(cnt4_q, cnt3_q, cnt2_q);
          end
        end
      end
      StPlace: begin
        // A simultaneous right-click is dropped so the committed orientation matches
        // the one that was being previewed.
        if (lclk) begin
          state_d = StCommit;
        end else if (rclk) begin
          direction_d = ~direction_q;
        end
      end
      StCommit: begin
        if (ship_placed) begin
          case (dimension_q)
            4'd4:    cnt4_d = cnt4_q - 4'd1;
            4'd3:    cnt3_d = cnt3_q - 4'd1;
            4'd2:    cnt2_d = cnt2_q - 4'd1;
            default: ;
          endcase
          ships_left_d = ships_left_q - 4'd1;
          if (ships_left_q == 4'd1) begin
            state_d = StShoot;
          end else begin
            state_d     = StPlace;
            dimension_d = first_dim(cnt4_d, cnt3_d, cnt2_d);
          end
        end else begin
          place_err_d = 1'b1;
          state_d     = StPlace;
        end
      end
      StShoot: ;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    unique case (state_d)
      StPlace:  play_status_d = 2'd1;
      StCommit: begin
        play_status_d = 2'd1;
        we_d          = 1'b1;
      end
      StShoot: begin
        play_status_d = 2'd2;
        fleet_done_d  = 1'b1;
        dimension_d   = 4'd0;
      end
      default: begin
        play_status_d = 2'd0;
        dimension_d   = 4'd0;
      end
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      cnt4_q        <= Cnt4Init;
      cnt3_q        <= Cnt3Init;
      cnt2_q        <= Cnt2Init;
      ships_left_q  <= TotalInit;
      dimension_q   <= 4'd0;
      direction_q   <= 1'b0;
      we_q          <= 1'b0;
      place_err_q   <= 1'b0;
      fleet_done_q  <= 1'b0;
      play_status_q <= 2'd0;
      // Preset high so a button already held through reset is not seen as a click.
      lbtn_q        <= 1'b1;
      rbtn_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt4_q        <= cnt4_d;
      cnt3_q        <= cnt3_d;
      cnt2_q        <= cnt2_d;
      ships_left_q  <= ships_left_d;
      dimension_q   <= dimension_d;
      direction_q   <= direction_d;
      we_q          <= we_d;
      place_err_q   <= place_err_d;
      fleet_done_q  <= fleet_done_d;
      play_status_q <= play_status_d;
      lbtn_q        <= left_btn;
      rbtn_q        <= right_btn;
    end
  end

  assign play_status = play_status_q;
  assign dimension   = dimension_q;
  assign direction   = direction_q;
  assign we          = we_q;
  assign ships_left  = ships_left_q;
  assign place_err   = place_err_q;
  assign fleet_done  = fleet_done_q;

endmodule

// File: tb/tb_fleet_placer.sv
// Directed bench for fleet_placer: default fleet, a single-ship fleet and an empty fleet
// share one stimulus stream; expected values are worked out by hand.
module tb_fleet_placer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic lb = 1'b0;
  logic rb = 1'b0;
  logic ack = 1'b1;

  logic [1:0] ps_d, ps_z, ps_e;
  logic [3:0] dim_d, dim_z, dim_e;
  logic       dir_d, dir_z, dir_e;
  logic       we_d, we_z, we_e;
  logic [3:0] sl_d, sl_z, sl_e;
  logic       err_d, err_z, err_e;
  logic       fd_d, fd_z, fd_e;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fleet_placer u_dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .left_btn(lb), .right_btn(rb),
    .ship_placed(ack), .play_status(ps_d), .dimension(dim_d), .direction(dir_d),
    .we(we_d), .ships_left(sl_d), .place_err(err_d), .fleet_done(fd_d)
  );

  fleet_placer #(.N_SHIP4(0), .N_SHIP3(0), .N_SHIP2(1)) u_one (
    .clk_in(clk), .rst_in(rst), .start_in(start), .left_btn(lb), .right_btn(rb),
    .ship_placed(ack), .play_status(ps_z), .dimension(dim_z), .direction(dir_z),
    .we(we_z), .ships_left(sl_z), .place_err(err_z), .fleet_done(fd_z)
  );

  fleet_placer #(.N_SHIP4(0), .N_SHIP3(0), .N_SHIP2(0)) u_empty (
    .clk_in(clk), .rst_in(rst), .start_in(start), .left_btn(lb), .right_btn(rb),
    .ship_placed(ack), .play_status(ps_e), .dimension(dim_e), .direction(dir_e),
    .we(we_e), .ships_left(sl_e), .place_err(err_e), .fleet_done(fd_e)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Acknowledged left-click; checks the strobe cycle and the cycle after it.
  task automatic click_ok(input string tag, input logic [3:0] dim_commit,
                          input logic [3:0] dim_after, input logic [3:0] left_after,
                          input logic [1:0] ps_after);
    lb = 1'b1;
    tick();
    check({tag, "_we"}, 8'(we_d), 8'd1);
    check({tag, "_dim_commit"}, 8'(dim_d), 8'(dim_commit));
    tick();
    check({tag, "_we_off"}, 8'(we_d), 8'd0);
    check({tag, "_dim_after"}, 8'(dim_d), 8'(dim_after));
    check({tag, "_left"}, 8'(sl_d), 8'(left_after));
    check({tag, "_ps"}, 8'(ps_d), 8'(ps_after));
    lb = 1'b0;
    tick();
  endtask

  initial begin
    // Reset, with a button held to confirm it is not taken as a click afterwards.
    lb  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ps", 8'(ps_d), 8'd0);
    check("rst_dim", 8'(dim_d), 8'd0);
    check("rst_dir", 8'(dir_d), 8'd0);
    check("rst_we", 8'(we_d), 8'd0);
    check("rst_left", 8'(sl_d), 8'd6);
    check("rst_err", 8'(err_d), 8'd0);
    check("rst_fd", 8'(fd_d), 8'd0);
    tick();
    check("held_idle_we", 8'(we_d), 8'd0);
    lb = 1'b0;
    tick();

    // Start deployment.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ps", 8'(ps_d), 8'd1);
    check("start_dim", 8'(dim_d), 8'd4);
    check("start_left", 8'(sl_d), 8'd6);
    check("start_dir", 8'(dir_d), 8'd0);
    check("one_start_dim", 8'(dim_z), 8'd2);
    check("one_start_left", 8'(sl_z), 8'd1);
    check("empty_ps", 8'(ps_e), 8'd2);
    check("empty_fd", 8'(fd_e), 8'd1);
    check("empty_dim", 8'(dim_e), 8'd0);

    // Three right-clicks toggle direction 1,0,1; holding does not repeat.
    rb = 1'b1; tick(); check("rclk1_dir", 8'(dir_d), 8'd1);
    tick();            check("rhold_dir", 8'(dir_d), 8'd1);
    rb = 1'b0; tick();
    rb = 1'b1; tick(); check("rclk2_dir", 8'(dir_d), 8'd0);
    rb = 1'b0; tick();
    rb = 1'b1; tick(); check("rclk3_dir", 8'(dir_d), 8'd1);
    rb = 1'b0; tick();

    // Refused commit.
    ack = 1'b0;
    lb  = 1'b1;
    tick();
    check("ref_we", 8'(we_d), 8'd1);
    check("ref_err_pre", 8'(err_d), 8'd0);
    tick();
    check("ref_we_off", 8'(we_d), 8'd0);
    check("ref_err", 8'(err_d), 8'd1);
    check("ref_left", 8'(sl_d), 8'd6);
    check("ref_dim", 8'(dim_d), 8'd4);
    check("ref_ps", 8'(ps_d), 8'd1);
    check("one_ref_left", 8'(sl_z), 8'd1);
    tick();
    check("ref_err_once", 8'(err_d), 8'd0);
    check("ref_hold_we", 8'(we_d), 8'd0);
    lb  = 1'b0;
    ack = 1'b1;
    tick();

    // Left and right rising together: commit wins, direction stays 1.
    lb = 1'b1;
    rb = 1'b1;
    tick();
    check("both_we", 8'(we_d), 8'd1);
    check("both_dir", 8'(dir_d), 8'd1);
    check("both_dim", 8'(dim_d), 8'd4);
    tick();
    check("both_dir_after", 8'(dir_d), 8'd1);
    check("both_left", 8'(sl_d), 8'd5);
    check("both_dim_after", 8'(dim_d), 8'd3);
    check("one_shoot_ps", 8'(ps_z), 8'd2);
    check("one_shoot_fd", 8'(fd_z), 8'd1);
    check("one_shoot_left", 8'(sl_z), 8'd0);
    check("one_shoot_dim", 8'(dim_z), 8'd0);
    lb = 1'b0;
    rb = 1'b0;
    tick();

    // Remainder of the fleet: commit dims 3,3,2,2,2.
    click_ok("c2", 4'd3, 4'd3, 4'd4, 2'd1);
    click_ok("c3", 4'd3, 4'd2, 4'd3, 2'd1);
    click_ok("c4", 4'd2, 4'd2, 4'd2, 2'd1);
    click_ok("c5", 4'd2, 4'd2, 4'd1, 2'd1);
    click_ok("c6", 4'd2, 4'd0, 4'd0, 2'd2);
    check("done_fd", 8'(fd_d), 8'd1);

    // SHOOT is terminal: clicks do nothing.
    lb = 1'b1;
    tick();
    check("shoot_we", 8'(we_d), 8'd0);
    check("shoot_ps", 8'(ps_d), 8'd2);
    lb = 1'b0;
    tick();

    // Reset during the commit strobe drops the commit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_ps", 8'(ps_d), 8'd0);
    check("rst2_left", 8'(sl_d), 8'd6);
    check("rst2_fd", 8'(fd_d), 8'd0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst2_start_dim", 8'(dim_d), 8'd4);
    lb = 1'b1;
    tick();
    check("mid_we", 8'(we_d), 8'd1);
    rst = 1'b1;
    ack = 1'b1;
    lb  = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_we_off", 8'(we_d), 8'd0);
    check("mid_ps", 8'(ps_d), 8'd0);
    check("mid_left", 8'(sl_d), 8'd6);
    check("mid_dim", 8'(dim_d), 8'd0);
    check("mid_err", 8'(err_d), 8'd0);
    tick();
    check("mid_idle_ps", 8'(ps_d), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fleet_placer.md
# fleet_placer

Placement sequencer that drives the board memory block during the deployment phase. It generates `play_status`, the current ship `dimension` and `direction`, and a one-cycle write-enable. Ships are committed on left-click and counted through the memory block's `ship_placed` acknowledge. When the whole fleet is deployed, it hands the game over to the shooting phase. It sits directly upstream of the cell memory, between the mouse/button front-end and the board store.

## Interface
Parameters:
- `N_SHIP4`, default 1: number of 4-cell ships.
- `N_SHIP3`, default 2: number of 3-cell ships.
- `N_SHIP2`, default 3: number of 2-cell ships.
- Constraint: the sum of the three must be ≤ 15.

Ports:
- `clk_in`  in  1  system clock. All state updates on the posedge.
- `rst_in`  in  1  synchronous reset, active-high.
- `start_in`  in  1  level; a high value in IDLE starts deployment.
- `left_btn`  in  1  mouse left button level, already synchronous to `clk_in`.
- `right_btn`  in  1  mouse right button level, already synchronous to `clk_in`.
- `ship_placed`  in  1  acknowledge from the board memory.
- `play_status`  out  2  0 = idle, 1 = deployment, 2 = shooting.
- `dimension`  out  4  length of the ship being placed; 0 outside deployment.
- `direction`  out  1  0 = ship extends along +x, 1 = along +y.
- `we`  out  1  commit strobe to the board memory.
- `ships_left`  out  4  ships not yet placed.
- `place_err`  out  1  one-cycle pulse when a commit is refused.
- `fleet_done`  out  1  high while in the SHOOT state.

## Operation
- **Outputs are registered.** `left_btn` and `right_btn` each get a one-register rising-edge detector (`lclk`, `rclk`). Holding a button never repeats an action.
- **Ship order:** all 4-cell ships, then all 3-cell ships, then all 2-cell ships. A class with a zero count is skipped. Per-class remaining counters decrement on each successful commit.
- **IDLE:**
  - `play_status`=0, `dimension`=0, `we`=0.
  - `start_in`=1 → PLACE, with `dimension` set to the first non-empty class.
  - If the total is 0, go to SHOOT instead.
- **PLACE:**
  - `play_status`=1, `we`=0. The board memory is previewing.
  - `rclk` toggles `direction`.
  - `lclk` → COMMIT.
  - If `lclk` and `rclk` occur in the same cycle, `lclk` wins and `rclk` is discarded.
- **COMMIT (exactly one cycle):**
  - `we`=1. `dimension` and `direction` are held; right-click edges are discarded.
  - At the closing posedge, `ship_placed` is sampled:
    - `ship_placed`=1: decrement `ships_left` and the class counter, then advance `dimension` to the next non-empty class. If this was the last ship → SHOOT, otherwise → PLACE.
    - `ship_placed`=0: counters are unchanged, `place_err`=1 for one cycle, → PLACE.
- **SHOOT:**
  - `play_status`=2, `dimension`=0, `we`=0, `fleet_done`=1.
  - Terminal state; only `rst_in` exits.
- **Reset values:**
  - `play_status`=0, `dimension`=0, `direction`=0, `we`=0.
  - `ships_left`=`N_SHIP4`+`N_SHIP3`+`N_SHIP2`, `place_err`=0, `fleet_done`=0.
  - Edge-detect registers are loaded with 1, so a button already held at reset is not counted.
- **Reset mid-operation:** `rst_in` in any state, including COMMIT, returns to IDLE with the reset values next cycle. Any in-flight commit is dropped. Clearing the board contents is not this block's job.

## Timing
- The board memory updates on the negedge. With `we` high during cycle k, its acknowledge is set mid-cycle k and is sampled at the posedge ending cycle k. The acknowledge window is therefore exactly one cycle, with no wait states.
- Latencies from the detected posedge:
  - Left-click to `we`: 1 cycle.
  - Right-click to `direction` toggle: 1 cycle.
- New `dimension` and `ships_left` are visible the cycle after COMMIT, together with `play_status` returning to 1.
- Last successful commit → `play_status`=2 and `fleet_done`=1 in the following cycle.
- `we` is never high for two consecutive cycles. The minimum spacing between commits is 2 cycles, plus button release and re-press.
- `ships_left` never underflows: COMMIT is unreachable when it is 0.

## Test plan
1. **Reset with default parameters:** reset, then `start_in`=1 → `play_status`=1, `dimension`=4, `ships_left`=6, `direction`=0.
2. **Full fleet:** six left-clicks, each acknowledged → `dimension` sequence 4,3,3,2,2,2. One cycle after the sixth COMMIT: `play_status`=2, `dimension`=0, `fleet_done`=1, `ships_left`=0.
3. **Refused commit:** left-click with `ship_placed` held 0 → one `we` pulse, `place_err` pulse the next cycle, `ships_left` stays 6, `dimension` stays 4.
4. **Direction toggles:**
   - Right-click three times → `direction` 1,0,1.
   - Right and left rising in the same cycle → COMMIT taken, `direction` unchanged.
5. **Reset mid-COMMIT:** assert `rst_in` during the `we` cycle with `ship_placed`=1 → next cycle IDLE, `ships_left`=6, `we`=0, no decrement.
6. **Zero-count classes:** `N_SHIP4`=0, `N_SHIP3`=0, `N_SHIP2`=1 → start gives `dimension`=2. One acknowledged commit → SHOOT. With all parameters 0, start goes directly to `play_status`=2.
